// File: rtl/cache_waymask_ctrl.sv
// Per-DSid way-partition controller: waymask lookup, occupancy tracking from
// tag updates, and threshold-crossing trigger events on an AXI-stream port.
module cache_waymask_ctrl #(
  parameter int NUM_DSID = 4,
  parameter int NUM_WAYS = 16,
  parameter int OCC_W    = 16
) (
  input  logic                      SYS_CLK,
  input  logic                      RST_N,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [15:0]               cfg_dsid,
  input  logic [NUM_WAYS-1:0]       cfg_waymask,
  input  logic [OCC_W-1:0]          cfg_threshold,
  input  logic                      lookup_valid,
  input  logic [15:0]               lookup_dsid,
  output logic [NUM_WAYS-1:0]       way_mask_to_cache,
  input  logic                      update_tag_en,
  input  logic [NUM_WAYS-1:0]       update_tag_we,
  input  logic [16*NUM_WAYS-1:0]    update_tag_old_dsid_vec,
  input  logic [16*NUM_WAYS-1:0]    update_tag_new_dsid_vec,
  output logic [OCC_W*NUM_DSID-1:0] occupancy_flat,
  input  logic                      trigger_axis_tready,
  output logic                      trigger_axis_tvalid,
  output logic [15:0]               trigger_axis_tdata
);
  localparam int IDX_W = (NUM_DSID > 1) ? $clog2(NUM_DSID) : 1;
  localparam int CNT_W = $clog2(NUM_WAYS + 1);
  localparam int SUM_W = OCC_W + 1;

  typedef enum logic {S_IDLE, S_APPLY} cfg_state_e;

  function automatic logic in_range(input logic [15:0] dsid);
    return dsid < 16'(NUM_DSID);
  endfunction

  function automatic logic [CNT_W-1:0] count_ways(input logic [16*NUM_WAYS-1:0] vec,
                                                  input logic [NUM_WAYS-1:0]    we,
                                                  input int                     idx);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (we[w] && vec[w*16 +: 16] == 16'(idx)) n = n + CNT_W'(1);
    return n;
  endfunction

  function automatic logic [OCC_W-1:0] sat_update(input logic [OCC_W-1:0] occ,
                                                  input logic [CNT_W-1:0] inc,
                                                  input logic [CNT_W-1:0] dec);
    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] diff;
    logic [OCC_W-1:0] res;
    up   = {1'b0, occ} + SUM_W'(inc);
    diff = up - SUM_W'(dec);
    if (up < SUM_W'(dec))  res = '0;
    else if (diff[OCC_W])  res = '1;
    else                   res = diff[OCC_W-1:0];
    return res;
  endfunction

  // Config FSM: request is latched on accept and applied in the following cycle.
  cfg_state_e           state_q;
  logic                 cfg_ready_q;
  logic                 cfg_hit_q;
  logic [IDX_W-1:0]     cfg_idx_q;
  logic [NUM_WAYS-1:0]  cfg_mask_q;
  logic [OCC_W-1:0]     cfg_thr_q;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cfg_ready_q <= 1'b1;
      cfg_hit_q   <= 1'b0;
      cfg_idx_q   <= '0;
      cfg_mask_q  <= '0;
      cfg_thr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            state_q     <= S_APPLY;
            cfg_ready_q <= 1'b0;
            cfg_hit_q   <= in_range(cfg_dsid);
            cfg_idx_q   <= cfg_dsid[IDX_W-1:0];
            cfg_mask_q  <= cfg_waymask;
            cfg_thr_q   <= cfg_threshold;
          end
        end
        S_APPLY: begin
          state_q     <= S_IDLE;
          cfg_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  logic apply_en;
  assign apply_en  = (state_q == S_APPLY) && cfg_hit_q;
  assign cfg_ready = cfg_ready_q;

  logic [NUM_WAYS-1:0] mask_q [NUM_DSID];
  logic [NUM_WAYS-1:0] mask_d [NUM_DSID];
  logic [OCC_W-1:0]    thr_q  [NUM_DSID];
  logic [OCC_W-1:0]    thr_d  [NUM_DSID];
  logic [OCC_W-1:0]    occ_q  [NUM_DSID];
  logic [OCC_W-1:0]    occ_d  [NUM_DSID];
  logic [NUM_WAYS-1:0] way_mask_q, way_mask_d;
  logic [NUM_DSID-1:0] armed_q, armed_d;
  logic [NUM_DSID-1:0] pending_q, pending_d;
  logic                tvalid_q, tvalid_d;
  logic [15:0]         tdata_q, tdata_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;

  // NOTE: always_comb uses blocking '=' with a default assigned first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_DSID; i++) begin
      mask_d[i] = mask_q[i];
      thr_d[i]  = thr_q[i];
      occ_d[i]  = occ_q[i];
      if (update_tag_en)
        occ_d[i] = sat_update(occ_q[i],
                              count_ways(update_tag_new_dsid_vec, update_tag_we, i),
                              count_ways(update_tag_old_dsid_vec, update_tag_we, i));
    end
    if (apply_en) begin
      mask_d[cfg_idx_q] = cfg_mask_q;
      thr_d[cfg_idx_q]  = cfg_thr_q;
    end
  end

  always_comb begin
    way_mask_d = way_mask_q;
    if (lookup_valid)
      way_mask_d = in_range(lookup_dsid) ? mask_q[lookup_dsid[IDX_W-1:0]] : '1;
  end

  logic             grant_found, issue;
  logic [IDX_W-1:0] grant_idx, cand;

  // Round-robin search begins one past the last granted entry.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_DSID; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_DSID);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    issue = (!tvalid_q || trigger_axis_tready) && grant_found;
  end

  always_comb begin
    armed_d      = armed_q;
    pending_d    = pending_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < NUM_DSID; i++) begin
      if (armed_q[i] && occ_d[i] > thr_q[i]) begin
        armed_d[i] = 1'b0;
        // An entry still waiting on its handshake must not be queued twice.
        if (!(tvalid_q && !trigger_axis_tready && tdata_q == 16'(i)))
          pending_d[i] = 1'b1;
      end else if (occ_d[i] <= thr_q[i]) begin
        armed_d[i] = 1'b1;
      end
    end
    if (issue) begin
      pending_d[grant_idx] = 1'b0;
      tvalid_d             = 1'b1;
      tdata_d              = 16'(grant_idx);
      last_grant_d         = grant_idx;
    end else if (tvalid_q && trigger_axis_tready) begin
      tvalid_d = 1'b0;
    end
    if (apply_en) begin
      pending_d[cfg_idx_q] = 1'b0;
      armed_d[cfg_idx_q]   = 1'b1;
    end
  end

  // NOTE: the per-DSid tables are reset because all-ones masks/thresholds are the power-on policy.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_DSID; i++) begin
        mask_q[i] <= '1;
        thr_q[i]  <= '1;
        occ_q[i]  <= '0;
      end
      way_mask_q   <= '1;
      armed_q      <= '1;
      pending_q    <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      last_grant_q <= IDX_W'(NUM_DSID - 1);
    end else begin
      for (int i = 0; i < NUM_DSID; i++) begin
        mask_q[i] <= mask_d[i];
        thr_q[i]  <= thr_d[i];
        occ_q[i]  <= occ_d[i];
      end
      way_mask_q   <= way_mask_d;
      armed_q      <= armed_d;
      pending_q    <= pending_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DSID; i++)
      occupancy_flat[i*OCC_W +: OCC_W] = occ_q[i];
  end

  assign way_mask_to_cache   = way_mask_q;
  assign trigger_axis_tvalid = tvalid_q;
  assign trigger_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_cache_waymask_ctrl.sv
// Directed bench for cache_waymask_ctrl: lookup, config, occupancy and trigger scenarios.
module tb_cache_waymask_ctrl;
  localparam int NUM_DSID = 4;
  localparam int NUM_WAYS = 16;
  localparam int OCC_W    = 16;

  logic                      SYS_CLK = 1'b0;
  logic                      RST_N;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [15:0]               cfg_dsid;
  logic [NUM_WAYS-1:0]       cfg_waymask;
  logic [OCC_W-1:0]          cfg_threshold;
  logic                      lookup_valid;
  logic [15:0]               lookup_dsid;
  logic [NUM_WAYS-1:0]       way_mask_to_cache;
  logic                      update_tag_en;
  logic [NUM_WAYS-1:0]       update_tag_we;
  logic [16*NUM_WAYS-1:0]    update_tag_old_dsid_vec;
  logic [16*NUM_WAYS-1:0]    update_tag_new_dsid_vec;
  logic [OCC_W*NUM_DSID-1:0] occupancy_flat;
  logic                      trigger_axis_tready;
  logic                      trigger_axis_tvalid;
  logic [15:0]               trigger_axis_tdata;

  int tests_run    = 0;
  int tests_failed = 0;

  cache_waymask_ctrl #(.NUM_DSID(NUM_DSID), .NUM_WAYS(NUM_WAYS), .OCC_W(OCC_W)) dut (
    .SYS_CLK                 (SYS_CLK),
    .RST_N                   (RST_N),
    .cfg_valid               (cfg_valid),
    .cfg_ready               (cfg_ready),
    .cfg_dsid                (cfg_dsid),
    .cfg_waymask             (cfg_waymask),
    .cfg_threshold           (cfg_threshold),
    .lookup_valid            (lookup_valid),
    .lookup_dsid             (lookup_dsid),
    .way_mask_to_cache       (way_mask_to_cache),
    .update_tag_en           (update_tag_en),
    .update_tag_we           (update_tag_we),
    .update_tag_old_dsid_vec (update_tag_old_dsid_vec),
    .update_tag_new_dsid_vec (update_tag_new_dsid_vec),
    .occupancy_flat          (occupancy_flat),
    .trigger_axis_tready     (trigger_axis_tready),
    .trigger_axis_tvalid     (trigger_axis_tvalid),
    .trigger_axis_tdata      (trigger_axis_tdata)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask

  function automatic logic [15:0] occ(input int i);
    return occupancy_flat[i*OCC_W +: OCC_W];
  endfunction

  task automatic do_cfg(input logic [15:0] dsid, input logic [15:0] mask, input logic [15:0] thr);
    cfg_valid = 1'b1; cfg_dsid = dsid; cfg_waymask = mask; cfg_threshold = thr;
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic do_lookup(input logic [15:0] dsid, output logic [15:0] mask);
    lookup_valid = 1'b1; lookup_dsid = dsid;
    step();
    lookup_valid = 1'b0;
    mask = way_mask_to_cache;
  endtask

  task automatic do_update(input logic [15:0] we, input logic [255:0] old_v, input logic [255:0] new_v);
    update_tag_en = 1'b1; update_tag_we = we;
    update_tag_old_dsid_vec = old_v; update_tag_new_dsid_vec = new_v;
    step();
    update_tag_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] m;
    RST_N = 1'b0;
    cfg_valid = 1'b0; cfg_dsid = '0; cfg_waymask = '0; cfg_threshold = '0;
    lookup_valid = 1'b0; lookup_dsid = '0;
    update_tag_en = 1'b0; update_tag_we = '0;
    update_tag_old_dsid_vec = '0; update_tag_new_dsid_vec = '0;
    trigger_axis_tready = 1'b0;
    repeat (3) @(posedge SYS_CLK);
    #1 RST_N = 1'b1;
    step();
    tests_run++; if (way_mask_to_cache !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_mask: got %h expected ffff", way_mask_to_cache); end
    tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    tests_run++; if (trigger_axis_tvalid !== 1'b0 || trigger_axis_tdata !== 16'h0) begin tests_failed++; $display("FAIL reset_trigger: got v=%b d=%h expected v=0 d=0000", trigger_axis_tvalid, trigger_axis_tdata); end
    tests_run++; if (occupancy_flat !== 64'h0) begin tests_failed++; $display("FAIL reset_occ: got %h expected 0", occupancy_flat); end
    do_lookup(16'd2, m);
    tests_run++; if (m !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_lookup2: got %h expected ffff", m); end
  endtask

  task automatic test_config();
    logic [15:0] m;
    tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL cfg_ready_idle: got %b expected 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_dsid = 16'd1; cfg_waymask = 16'h00F0; cfg_threshold = 16'hFFFF;
    step();
    cfg_valid = 1'b0;
    tests_run++; if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL cfg_ready_apply: got %b expected 0", cfg_ready); end
    step();
    tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL cfg_ready_back: got %b expected 1", cfg_ready); end
    do_lookup(16'd1, m);
    tests_run++; if (m !== 16'h00F0) begin tests_failed++; $display("FAIL lookup_dsid1: got %h expected 00f0", m); end
    do_lookup(16'd9, m);
    tests_run++; if (m !== 16'hFFFF) begin tests_failed++; $display("FAIL lookup_oor9: got %h expected ffff", m); end
    do_lookup(16'd1, m);
    step();
    tests_run++; if (way_mask_to_cache !== 16'h00F0) begin tests_failed++; $display("FAIL lookup_hold: got %h expected 00f0", way_mask_to_cache); end
    // Lookup issued during the APPLY cycle sees the previous mask.
    cfg_valid = 1'b1; cfg_dsid = 16'd2; cfg_waymask = 16'h0F0F; cfg_threshold = 16'hFFFF;
    step();
    cfg_valid = 1'b0;
    do_lookup(16'd2, m);
    tests_run++; if (m !== 16'hFFFF) begin tests_failed++; $display("FAIL lookup_in_apply: got %h expected ffff", m); end
    do_lookup(16'd2, m);
    tests_run++; if (m !== 16'h0F0F) begin tests_failed++; $display("FAIL lookup_after_apply: got %h expected 0f0f", m); end
    do_cfg(16'd5, 16'h1234, 16'h0000);
    do_lookup(16'd1, m);
    tests_run++; if (m !== 16'h00F0) begin tests_failed++; $display("FAIL cfg_oor_nowrite: got %h expected 00f0", m); end
  endtask

  task automatic test_threshold_trigger();
    logic [255:0] old_v, new_v;
    do_cfg(16'd0, 16'hFFFF, 16'd3);
    old_v = {NUM_WAYS{16'hFFFF}}; old_v[15:0] = 16'd3;
    new_v = {NUM_WAYS{16'hFFFF}}; new_v[15:0] = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      do_update(16'h0001, old_v, new_v);
      tests_run++; if (occ(0) !== 16'(k) || occ(3) !== 16'h0) begin tests_failed++; $display("FAIL occ_step%0d: got occ0=%0d occ3=%0d expected occ0=%0d occ3=0", k, occ(0), occ(3), k); end
    end
    tests_run++; if (trigger_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL trig_not_early: got %b expected 0", trigger_axis_tvalid); end
    step();
    tests_run++; if (trigger_axis_tvalid !== 1'b1 || trigger_axis_tdata !== 16'h0000) begin tests_failed++; $display("FAIL trig_dsid0: got v=%b d=%h expected v=1 d=0000", trigger_axis_tvalid, trigger_axis_tdata); end
    trigger_axis_tready = 1'b1;
    step();
    trigger_axis_tready = 1'b0;
    tests_run++; if (trigger_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL trig_drop: got %b expected 0", trigger_axis_tvalid); end
    repeat (3) step();
    tests_run++; if (trigger_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL trig_single: got %b expected 0", trigger_axis_tvalid); end
  endtask

  task automatic test_multi_way();
    do_update(16'h000F, {NUM_WAYS{16'hFFFF}}, {NUM_WAYS{16'd1}});
    tests_run++; if (occ(1) !== 16'd4) begin tests_failed++; $display("FAIL occ1_preload: got %0d expected 4", occ(1)); end
    do_update(16'h0003, {NUM_WAYS{16'd1}}, {NUM_WAYS{16'd2}});
    tests_run++; if (occ(2) !== 16'd2 || occ(1) !== 16'd2 || occ(0) !== 16'd4) begin tests_failed++; $display("FAIL occ_multi_way: got occ0=%0d occ1=%0d occ2=%0d expected 4 2 2", occ(0), occ(1), occ(2)); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] new_v;
    do_cfg(16'd1, 16'h00F0, 16'd2);
    do_cfg(16'd2, 16'h0F0F, 16'd2);
    new_v = {NUM_WAYS{16'hFFFF}}; new_v[15:0] = 16'd1; new_v[31:16] = 16'd2;
    do_update(16'h0003, {NUM_WAYS{16'hFFFF}}, new_v);
    tests_run++; if (occ(1) !== 16'd3 || occ(2) !== 16'd3 || trigger_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL b2b_cross: got occ1=%0d occ2=%0d v=%b expected 3 3 v=0", occ(1), occ(2), trigger_axis_tvalid); end
    step();
    for (int k = 0; k < 5; k++) begin
      tests_run++; if (trigger_axis_tvalid !== 1'b1 || trigger_axis_tdata !== 16'd1) begin tests_failed++; $display("FAIL b2b_hold%0d: got v=%b d=%h expected v=1 d=0001", k, trigger_axis_tvalid, trigger_axis_tdata); end
      step();
    end
    trigger_axis_tready = 1'b1;
    step();
    tests_run++; if (trigger_axis_tvalid !== 1'b1 || trigger_axis_tdata !== 16'd2) begin tests_failed++; $display("FAIL b2b_second: got v=%b d=%h expected v=1 d=0002", trigger_axis_tvalid, trigger_axis_tdata); end
    step();
    trigger_axis_tready = 1'b0;
    tests_run++; if (trigger_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got %b expected 0", trigger_axis_tvalid); end
  endtask

  task automatic test_reset_midflight();
    logic [255:0] new_v;
    logic [15:0]  m;
    do_cfg(16'd3, 16'h0F00, 16'd0);
    new_v = {NUM_WAYS{16'hFFFF}}; new_v[15:0] = 16'd3;
    do_update(16'h0001, {NUM_WAYS{16'hFFFF}}, new_v);
    step();
    tests_run++; if (trigger_axis_tvalid !== 1'b1 || trigger_axis_tdata !== 16'd3) begin tests_failed++; $display("FAIL mid_trig3: got v=%b d=%h expected v=1 d=0003", trigger_axis_tvalid, trigger_axis_tdata); end
    cfg_valid = 1'b1; cfg_dsid = 16'd1; cfg_waymask = 16'h000F; cfg_threshold = 16'd7;
    step();
    cfg_valid = 1'b0;
    tests_run++; if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_in_apply: got %b expected 0", cfg_ready); end
    RST_N = 1'b0;
    #1;
    tests_run++; if (trigger_axis_tvalid !== 1'b0 || cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_async: got v=%b rdy=%b expected v=0 rdy=1", trigger_axis_tvalid, cfg_ready); end
    @(negedge SYS_CLK);
    @(negedge SYS_CLK);
    RST_N = 1'b1;
    step();
    tests_run++; if (trigger_axis_tvalid !== 1'b0 || cfg_ready !== 1'b1 || way_mask_to_cache !== 16'hFFFF) begin tests_failed++; $display("FAIL mid_release: got v=%b rdy=%b mask=%h expected v=0 rdy=1 mask=ffff", trigger_axis_tvalid, cfg_ready, way_mask_to_cache); end
    tests_run++; if (occupancy_flat !== 64'h0) begin tests_failed++; $display("FAIL mid_occ: got %h expected 0", occupancy_flat); end
    do_lookup(16'd1, m);
    tests_run++; if (m !== 16'hFFFF) begin tests_failed++; $display("FAIL mid_lookup1: got %h expected ffff", m); end
    do_lookup(16'd3, m);
    tests_run++; if (m !== 16'hFFFF) begin tests_failed++; $display("FAIL mid_lookup3: got %h expected ffff", m); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_threshold_trigger();
    test_multi_way();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
